mem_word_sequencer: RTL
=======================

Name: mem_word_sequencer

Overview:
- Sits between the multicycle RISC-V datapath and the byte-wide data memory (8-bit data, 5-bit address, 32 entries, asynchronous read, synchronous write).
- Turns one byte/half/word load or store request into 1, 2 or 4 sequential byte accesses, little-endian.
- Assembles and sign/zero-extends load data into a 32-bit result and signals completion with a one-cycle done pulse.

Parameters:
- DATA_WIDTH, 8, memory byte width; fixed at 8 for this block.
- ADDR_WIDTH, 5, memory address width; memory holds 2^ADDR_WIDTH bytes.
- WORD_WIDTH, 32, datapath word width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request strobe; sampled only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned  in  1  load zero-extend (1) or sign-extend (0).
- req_addr  in  ADDR_WIDTH  base byte address.
- req_wdata  in  WORD_WIDTH  store data; low bytes used for byte/half.
- busy  out  1  high in ACCESS and DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  misalignment flag; valid with done.
- rdata  out  WORD_WIDTH  extended load result; held until next accepted load.
- mem_addr  out  ADDR_WIDTH  to memory addr.
- mem_write  out  1  to memory write enable.
- mem_wdata  out  DATA_WIDTH  to memory data_in.
- mem_rdata  in  DATA_WIDTH  from memory data_out; combinational.

Behaviour:
- Reset values: state IDLE, cnt 0, busy 0, done 0, err 0, rdata 0, mem_addr 0, mem_write 0, mem_wdata 0.
- nbytes = 1 / 2 / 4 for byte / half / word.

State IDLE:
- On an edge with req_valid=1: latch write, size, unsigned, addr, wdata; cnt=0; go to ACCESS.
- req_valid is ignored in every other state; there is no queueing.

State ACCESS, one byte per cycle:
- mem_addr = base + cnt, modulo 2^ADDR_WIDTH, so accesses wrap past address 31 to 0.
- mem_wdata = wdata[8*cnt+7 : 8*cnt].
- mem_write = latched write flag; combinational from state, deasserted outside ACCESS.
- On each load edge, mem_rdata is captured into byte lane cnt of the assembly register.
- If cnt == nbytes-1, go to DONE; otherwise cnt++.

State DONE:
- done=1 for exactly one cycle.
- For loads, rdata is updated at the ACCESS-to-DONE edge: byte/half zero- or sign-extended from bit 7 or 15; word unchanged.
- Stores leave rdata unchanged.
- Next state IDLE. A new request is accepted no earlier than the cycle after DONE.

Latency, with the request sampled at edge E0:
- done is high in the cycle after edge E(nbytes).
- byte: done 2 cycles after acceptance; half: 3; word: 5.

Reset mid-operation:
- Immediate return to IDLE; mem_write drops without waiting for a clock.
- Bytes already written stay in memory; the partial store is not rolled back.
- rdata clears to 0.

Optional Feature:
- Macro: MEM_SEQ_ALIGN_CHECK_EN.
- Defined: a half request with addr[0]=1, or a word request with addr[1:0]!=0, performs no memory access. The FSM goes IDLE to DONE directly (done one cycle after acceptance) with err=1. rdata is forced to 0 for a misaligned load, and memory is untouched for a misaligned store.
- Not defined: err is tied 0; misaligned and wrapping accesses are performed byte-wise as described.

Test Plan:
- Word store 0xDEADBEEF at addr 4, then word load at addr 4:
  - memory bytes 4..7 = EF, BE, AD, DE;
  - rdata = 0xDEADBEEF;
  - each done is high exactly once, 5 cycles after acceptance.
- Byte store 0x80 at addr 9:
  - signed byte load gives rdata = 0xFFFFFF80;
  - unsigned byte load gives rdata = 0x00000080;
  - done is high 2 cycles after acceptance.
- Half store 0x1234 at addr 31 with the macro undefined:
  - bytes 31 = 34 and 0 = 12 (wrap);
  - signed half load at 31 gives 0x00001234.
- req_valid held high during a word load: no new request is accepted until after DONE; the second request starts the cycle after IDLE is re-entered.
- Word store 0xAABBCCDD at addr 8, with rst asserted mid-cycle after 2 write edges:
  - mem_write drops asynchronously and busy = 0;
  - bytes 8,9 = DD,CC and bytes 10,11 keep their old values;
  - rdata = 0.
- With the macro defined, word load at addr 6: no mem_write, no capture; done one cycle after acceptance with err=1 and rdata=0. An aligned word load at addr 4 then gives err=0.

Source files
------------

// File: rtl/mem_word_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_word_sequencer: splits byte/half/word loads and stores into          |
// | little-endian byte accesses; optional MEM_SEQ_ALIGN_CHECK_EN. Rev 1.0    |
// +--------------------------------------------------------------------------+
module mem_word_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [WORD_WIDTH-1:0] req_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [WORD_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_write,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [1:0]              cnt_q, cnt_d;
   logic                    write_q, write_d;
   logic [1:0]              size_q, size_d;
   logic                    uns_q, uns_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [WORD_WIDTH-1:0]   wdata_q, wdata_d;
   logic [WORD_WIDTH-1:0]   asm_q, asm_d;
   logic [WORD_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    done_q, done_d;
   logic                    busy_q, busy_d;
   logic                    err_q, err_d;

   logic                    misalign;
   logic [1:0]              last_idx;
   logic                    last;
   logic [WORD_WIDTH-1:0]   asm_next;
   logic [WORD_WIDTH-1:0]   ext;

`ifdef MEM_SEQ_ALIGN_CHECK_EN
   assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                     (req_size[1] && (req_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   // Size code 11 behaves exactly like a word.
   always_comb begin
      case (size_q)
         2'b00:   last_idx = 2'd0;
         2'b01:   last_idx = 2'd1;
         default: last_idx = 2'd3;
      endcase
   end

   assign last = (cnt_q == last_idx);

   // The final byte arrives on the same edge that publishes rdata, so merge it here.
   always_comb begin
      asm_next = asm_q;
      asm_next[cnt_q*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
   end

   always_comb begin
      case (size_q)
         2'b00:   ext = {{(WORD_WIDTH-DATA_WIDTH){~uns_q & asm_next[DATA_WIDTH-1]}},
                         asm_next[DATA_WIDTH-1:0]};
         2'b01:   ext = {{(WORD_WIDTH-2*DATA_WIDTH){~uns_q & asm_next[2*DATA_WIDTH-1]}},
                         asm_next[2*DATA_WIDTH-1:0]};
         default: ext = asm_next;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      size_d  = size_q;
      uns_d   = uns_q;
      base_d  = base_q;
      wdata_d = wdata_q;
      asm_d   = asm_q;
      rdata_d = rdata_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               size_d  = req_size;
               uns_d   = req_unsigned;
               base_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = 2'd0;
               if (misalign) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  if (!req_write) begin
                     rdata_d = '0;
                  end
               end else begin
                  state_d = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            if (!write_q) begin
               asm_d = asm_next;
            end
            if (last) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               if (!write_q) begin
                  rdata_d = ext;
               end
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         write_q <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         base_q  <= '0;
         wdata_q <= '0;
         asm_q   <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         base_q  <= base_d;
         wdata_q <= wdata_d;
         asm_q   <= asm_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   // Memory strobes decode straight from state so an async reset kills a write at once.
   assign mem_write = (state_q == S_ACCESS) && write_q;
   assign mem_addr  = (state_q == S_ACCESS) ? (base_q + ADDR_WIDTH'(cnt_q)) : '0;
   assign mem_wdata = (state_q == S_ACCESS) ? wdata_q[cnt_q*DATA_WIDTH +: DATA_WIDTH] : '0;

   assign busy  = busy_q;
   assign done  = done_q;
   assign err   = err_q;
   assign rdata = rdata_q;

endmodule
`default_nettype wire
